// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SIGN
    } muldiv_state_t;

    localparam int         ITERS     = 32;
    localparam logic [4:0] LAST_ITER = 5'(ITERS - 1);

    // Two's-complement magnitude; 33 bits so 2^31 and full unsigned words both fit.
    function automatic logic [32:0] magnitude(input logic [31:0] v, input logic is_signed);
        if (is_signed && v[31]) begin
            return {1'b0, ~v + 32'd1};
        end
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath: shift-add for multiply,
// restoring subtract for divide.
module muldiv_step
    import muldiv_pkg::*;
(
    input  muldiv_op_t  op_i,
    input  logic [64:0] acc_i,
    input  logic [32:0] op_a_i,
    input  logic [32:0] op_b_i,
    input  logic [4:0]  cnt_i,
    output logic [64:0] acc_o
);

    logic [31:0] mplier;
    logic [31:0] dividend;
    logic [64:0] addend;
    logic [32:0] shifted;
    logic [33:0] diff;
    logic [32:0] rem_next;
    logic        q_bit;

    // Divide keeps {remainder, quotient} in the accumulator; multiply keeps the running product.
    always_comb begin
        mplier   = op_b_i[31:0];
        dividend = op_a_i[31:0];
        addend   = {32'd0, op_a_i} << cnt_i;
        shifted  = {acc_i[63:32], dividend[5'd31 - cnt_i]};
        diff     = {1'b0, shifted} - {1'b0, op_b_i};
        q_bit    = ~diff[33];
        rem_next = q_bit ? diff[32:0] : shifted;
        if (op_i inside {DIV, DIVU}) begin
            acc_o = {rem_next, acc_i[30:0], q_bit};
        end else begin
            acc_o = acc_i + (mplier[cnt_i] ? addend : 65'd0);
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit mult/multu/div/divu unit with HI/LO registers and mthi/mtlo.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    muldiv_state_t state_q, state_d;
    muldiv_op_t    op_q, op_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [32:0]   a_mag_q, a_mag_d;
    logic [32:0]   b_mag_q, b_mag_d;
    logic [64:0]   acc_q, acc_d;
    logic          neg_lo_q, neg_lo_d;
    logic          neg_hi_q, neg_hi_d;
    logic          b_zero_q, b_zero_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic          done_q, done_d;

    logic [64:0]   step_acc;
    logic [63:0]   prod_fix;
    logic [31:0]   quot_fix;
    logic [31:0]   rem_fix;
    logic          is_signed;

    muldiv_step u_step (
        .op_i   (op_q),
        .acc_i  (acc_q),
        .op_a_i (a_mag_q),
        .op_b_i (b_mag_q),
        .cnt_i  (cnt_q),
        .acc_o  (step_acc)
    );

    assign is_signed = ~op[0];
    assign prod_fix  = neg_lo_q ? (~acc_q[63:0] + 64'd1) : acc_q[63:0];
    // Divide by zero reports an all-ones quotient; the remainder path already restores a.
    assign quot_fix  = b_zero_q ? 32'hFFFF_FFFF
                     : (neg_lo_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0]);
    assign rem_fix   = neg_hi_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

    // NOTE: every _d signal gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        acc_d    = acc_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        b_zero_d = b_zero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = CALC;
                    op_d     = muldiv_op_t'(op);
                    cnt_d    = 5'd0;
                    acc_d    = 65'd0;
                    a_mag_d  = magnitude(a, is_signed);
                    b_mag_d  = magnitude(b, is_signed);
                    neg_lo_d = is_signed & (a[31] ^ b[31]);
                    neg_hi_d = is_signed & a[31];
                    b_zero_d = (b == 32'd0);
                end else begin
                    if (mthi) hi_d = a;
                    if (mtlo) lo_d = a;
                end
            end
            CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) state_d = SIGN;
            end
            SIGN: begin
                case (op_q)
                    MULT, MULTU: begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end
                    default: begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end
                endcase
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_q     <= MULT;
            cnt_q    <= 5'd0;
            a_mag_q  <= 33'd0;
            b_mag_q  <= 33'd0;
            acc_q    <= 65'd0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            b_zero_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            acc_q    <= acc_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            b_zero_q <= b_zero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS execute stage, sitting beside the ALU and sharing its register-file operands. It runs mult, multu, div and divu over 32 cycles and holds the products and quotients in HI/LO. It also accepts mthi/mtlo writes. The datapath reads `hi`/`lo` for mfhi/mflo through the same writeback mux that carries the ALU `result`.

## Interface
Parameters:
- none; operand width is fixed at 32.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low; sampled on the rising edge of `clk`.
- `a` in 32: rs operand (multiplicand or dividend); also the write data for mthi/mtlo.
- `b` in 32: rt operand (multiplier or divisor).
- `start` in 1: launch the operation selected by `op`.
- `op` in 2: operation select.
  - 00 mult
  - 01 multu
  - 10 div
  - 11 divu
- `mthi` in 1: write `a` into HI.
- `mtlo` in 1: write `a` into LO.
- `busy` out 1: operation in progress; the controller stalls any mfhi/mflo/mult/div while it is high.
- `done` out 1: one-cycle pulse; HI/LO hold the new result.
- `hi` out 32: HI register (high product word, or remainder).
- `lo` out 32: LO register (low product word, or quotient).

## Operation
- States:
  - IDLE: `busy`=0.
  - CALC: 32 iterations, 5-bit counter.
  - SIGN: sign correction and HI/LO write.
- IDLE→CALC on `start`=1:
  - latch `op`.
  - latch |a| and |b| (two's-complement magnitude for mult/div, raw value for multu/divu), as 33-bit unsigned values.
  - latch the result signs.
    - Multiply: sign = a[31]^b[31].
    - Divide: quotient sign = a[31]^b[31]; remainder sign = a[31].
- CALC, multiply: radix-2 shift-add into a 64-bit accumulator, one multiplier bit per cycle, LSB first.
- CALC, divide: restoring division, one quotient bit per cycle, MSB first. The 33-bit partial remainder absorbs the 2^31 magnitude.
- CALC→SIGN when the counter reaches 31.
- SIGN:
  - Negate each result whose sign flag is set.
  - Write HI/LO.
  - Go to IDLE and assert `done` on the next cycle.
- Divide by zero (b=0): completes in normal time, with lo=32'hFFFFFFFF and hi=a (original a, no sign fix).
- Overflow 0x80000000 / -1 (div): lo=32'h80000000, hi=0. This falls out of the magnitude path with no special case.
- mthi/mtlo take effect only in IDLE with `start`=0; otherwise they are ignored. Both may be asserted together.
- `start` while not in IDLE is ignored.
- `start` and mthi/mtlo together in IDLE: `start` wins and the move is dropped.
- `hi`/`lo` keep their previous values until the SIGN write.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0.
- Start accepted at edge E0.
- `busy` is high from E0 through E33 (33 cycles).
- HI/LO are written at E33; `done`=1 during the cycle after E33, with `busy` already 0.
- Start-to-done latency: 34 edges.
- Back-to-back: a new `start` may be accepted on the cycle where `done`=1. That `done` pulse still occurs.
- mthi/mtlo latency: one edge; the new value is visible on `hi`/`lo` in the next cycle.
- Reset asserted mid-operation (any state):
  - state IDLE next cycle; `hi`=`lo`=0.
  - no `done` pulse for the aborted operation.
- `done` is never asserted for two consecutive cycles.

## Structure
- `muldiv_pkg`:
  - `muldiv_op_t` enum: MULT, MULTU, DIV, DIVU.
  - `muldiv_state_t` enum: IDLE, CALC, SIGN.
  - constant ITERS=32.
- One sub-module, `muldiv_step`: combinational single iteration. It takes op class, accumulator/remainder, operand and counter, and returns the next accumulator/remainder. The top level holds the FSM, counter, magnitude/sign capture and HI/LO registers.

## Test plan
- multu a=32'hFFFFFFFF, b=32'hFFFFFFFF → hi=32'hFFFFFFFE, lo=32'h00000001; `done` exactly 34 edges after start; `busy` high for 33 cycles.
- mult a=-3, b=5 → hi=32'hFFFFFFFF, lo=32'hFFFFFFF1. Also mult a=32'h80000000, b=32'h80000000 → hi=32'h40000000, lo=0.
- div a=-7, b=2 → lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. divu a=7, b=2 → lo=3, hi=1.
- div a=32'h80000000, b=32'hFFFFFFFF → lo=32'h80000000, hi=0. divu a=5, b=0 → lo=32'hFFFFFFFF, hi=5.
- Second `start` and an mthi (a=32'hDEADBEEF) at cycle 10 of a multu 3×4 → both ignored; result hi=0, lo=12.
- mthi and mtlo in IDLE → values visible next cycle.
- `reset`=0 at cycle 10 of a div → busy=0, hi=lo=0 next cycle, no `done` pulse.
